regfile_wport_arbiter: RTL and testbench
========================================

REGFILE_WPORT_ARBITER -- requirements
Module: regfile_wport_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 3, the number of consecutive cycles an LLU request may be refused before the pipeline is stalled (legal range 1..15).
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wb_valid  in  1  pipeline WB stage holds a register write.
REQ-006 wb_rd  in  5  pipeline WB destination register.
REQ-007 wb_data  in  32  pipeline WB write data.
REQ-008 llu_valid  in  1  long-latency unit (mul/div/load-miss) result available.
REQ-009 llu_rd  in  5  LLU destination register.
REQ-010 llu_data  in  32  LLU result data.
REQ-011 llu_ready  out  1  LLU result is accepted this cycle (combinational).
REQ-012 stall_pipe  out  1  registered; freezes the pipeline and inserts WB bubbles.
REQ-013 RegWrite  out  1  registered register-file write enable.
REQ-014 w_add  out  5  registered register-file write address.
REQ-015 RegWriteData  out  32  registered register-file write data.

Function
REQ-016 A WB request SHALL be active when wb_valid=1 and wb_rd!=0; wb_valid with wb_rd=0 SHALL be ignored (no write, no port use).
REQ-017 The FSM SHALL have two states, NORMAL and FORCE.
REQ-018 In NORMAL, an active WB request SHALL win; llu_ready = llu_valid & ~(active WB).
REQ-019 In FORCE, llu_ready SHALL equal llu_valid & ~(active WB); a WB request still present in FORCE SHALL still win, and stall_pipe SHALL remain 1.
REQ-020 LLU handshake: a transfer occurs when llu_valid=1 and llu_ready=1; the LLU SHALL hold llu_rd/llu_data stable until transfer, and the block SHALL NOT depend on llu_valid deasserting early.
REQ-021 An LLU transfer with llu_rd=0 SHALL be consumed (llu_ready=1) without producing a write.
REQ-022 The write latency SHALL be one cycle: the granted source drives RegWrite=1, w_add, RegWriteData on the clock edge following the grant; with no grant RegWrite=0 and w_add/RegWriteData hold their previous values.
REQ-023 A starvation counter (4 bits, saturating at 15) SHALL increment each cycle with llu_valid=1 and llu_ready=0, and SHALL clear on an LLU transfer or when llu_valid=0.
REQ-024 NORMAL to FORCE SHALL occur on the edge where the counter value is STARVE_LIMIT-1 and the LLU is still refused; stall_pipe SHALL be 1 from that edge.
REQ-025 FORCE to NORMAL SHALL occur on the edge of the LLU transfer; stall_pipe SHALL be 0 from that edge and the counter SHALL clear.
REQ-026 If llu_valid drops while in FORCE, the FSM SHALL return to NORMAL on the next edge.
REQ-027 Simultaneous active WB and LLU requests SHALL produce exactly one write per cycle; there SHALL never be two writes or a lost WB write.

Reset
REQ-028 While rst=1 on a clock edge: state=NORMAL, counter=0, stall_pipe=0, RegWrite=0, w_add=0, RegWriteData=0.
REQ-029 llu_ready SHALL be 0 in any cycle with rst=1.
REQ-030 A reset asserted in FORCE SHALL drop stall_pipe on that same edge; an LLU result refused during reset SHALL NOT be written.

Structure
REQ-031 XLEN=32, REG_ADDR_W=5 and the FSM state encoding SHALL be in the shared riscv_pkg package.
REQ-032 The block SHALL be a single module with no sub-modules, and it SHALL instantiate no register file.

Verification
REQ-033 WB only: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> the next cycle has RegWrite=1, w_add=5, RegWriteData=0xDEADBEEF.
REQ-034 x0 drop: wb_rd=0, then llu_valid=1, llu_rd=0 -> llu_ready=1 and RegWrite stays 0 throughout.
REQ-035 Conflict: WB (rd=3) and LLU (rd=7, 0x12345678) in the same cycle -> x3 is written first, then x7 with 0x12345678 one cycle later when WB is idle.
REQ-036 Starvation: active WB every cycle plus a held LLU request with STARVE_LIMIT=3 -> stall_pipe rises after the 3rd refused cycle; once WB bubbles, the LLU transfers and stall_pipe falls on the next edge.
REQ-037 Reset in FORCE: rst=1 for one cycle while stall_pipe=1 -> stall_pipe=0, RegWrite=0, w_add=0 after the edge, with no spurious write.
REQ-038 Counter clear: the LLU is refused twice, then llu_valid drops -> the counter returns to 0 and a new request needs a full 3 refused cycles to assert stall_pipe.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared core-wide widths and the write-port arbiter FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int STARVE_CNT_W = 4;

  // Write-port arbiter states: NORMAL lets the pipeline win, FORCE holds the
  // pipeline frozen until the long-latency result drains.
  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wport_arbiter
//  Description : Arbitrates the single register-file write port between the
//                pipeline WB stage and a long-latency unit (mul/div/load
//                miss). WB has priority; a starved LLU result forces a
//                pipeline stall so WB bubbles can let it through.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wport_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  llu_valid,
  input  logic [REG_ADDR_W-1:0] llu_rd,
  input  logic [XLEN-1:0]       llu_data,
  output logic                  llu_ready,
  output logic                  stall_pipe,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] w_add,
  output logic [XLEN-1:0]       RegWriteData
);

  localparam logic [STARVE_CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [STARVE_CNT_W-1:0] c_FORCE_AT = STARVE_CNT_W'(STARVE_LIMIT - 1);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [STARVE_CNT_W-1:0] r_cnt;
  logic                    r_stall;
  logic                    r_wen;
  logic [REG_ADDR_W-1:0]   r_wadd;
  logic [XLEN-1:0]         r_wdata;

  logic w_wb_act;
  logic w_llu_rdy;
  logic w_llu_xfer;
  logic w_llu_refused;
  logic w_llu_wr;

  // Writes to x0 are architecturally discarded, so they never claim the port.
  assign w_wb_act      = wb_valid & (wb_rd != '0);
  // WB always wins the port, in both states; nothing is accepted during reset.
  assign w_llu_rdy     = ~rst & llu_valid & ~w_wb_act;
  assign w_llu_xfer    = llu_valid & w_llu_rdy;
  assign w_llu_refused = llu_valid & ~w_llu_rdy;
  // An x0-destined LLU result is consumed but produces no write.
  assign w_llu_wr      = w_llu_xfer & (llu_rd != '0);

  assign llu_ready    = w_llu_rdy;
  assign stall_pipe   = r_stall;
  assign RegWrite     = r_wen;
  assign w_add        = r_wadd;
  assign RegWriteData = r_wdata;

  // Next-state logic: enter FORCE on the refusal that reaches the limit,
  // leave it once the LLU result drains or is withdrawn.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_NORMAL: begin
        if (w_llu_refused && (r_cnt == c_FORCE_AT)) begin
          w_state_nxt = ARB_FORCE;
        end
      end
      ARB_FORCE: begin
        if (!llu_valid || w_llu_xfer) begin
          w_state_nxt = ARB_NORMAL;
        end
      end
      default: w_state_nxt = ARB_NORMAL;
    endcase
  end

  // State register; stall is registered from the next state so it tracks
  // FORCE on the very edge the state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_NORMAL;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stall <= (w_state_nxt == ARB_FORCE);
    end
  end

  // Saturating count of consecutive refused LLU cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!llu_valid || w_llu_xfer) begin
      r_cnt <= '0;
    end else if (r_cnt != c_CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Register-file write port: one write per cycle, address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_wadd  <= '0;
      r_wdata <= '0;
    end else if (w_wb_act) begin
      r_wen   <= 1'b1;
      r_wadd  <= wb_rd;
      r_wdata <= wb_data;
    end else if (w_llu_wr) begin
      r_wen   <= 1'b1;
      r_wadd  <= llu_rd;
      r_wdata <= llu_data;
    end else begin
      r_wen   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wport_arbiter
//  Description : Self-checking bench for regfile_wport_arbiter; expected
//                writes are queued when stimulus is applied and popped when
//                the write port fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wport_arbiter;

  localparam int LIMIT = 3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        stall_pipe;
  logic        RegWrite;
  logic [4:0]  w_add;
  logic [31:0] RegWriteData;

  int n_checks = 0;
  int n_errors = 0;

  wr_t exp_q[$];

  // Reference model state
  int          m_cnt   = 0;
  logic        m_force = 1'b0;
  logic        m_wen   = 1'b0;
  logic [4:0]  m_wadd  = '0;
  logic [31:0] m_wdata = '0;

  regfile_wport_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .llu_valid    (llu_valid),
    .llu_rd       (llu_rd),
    .llu_data     (llu_data),
    .llu_ready    (llu_ready),
    .stall_pipe   (stall_pipe),
    .RegWrite     (RegWrite),
    .w_add        (w_add),
    .RegWriteData (RegWriteData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs are applied just after a falling edge; check, advance one clock.
  task automatic step(output logic xfer);
    logic wb_act, rdy, have, force_n;
    wr_t  w;
    #1;
    wb_act = wb_valid && (wb_rd != 5'd0);
    rdy    = !rst && llu_valid && !wb_act;
    xfer   = llu_valid && rdy;
    chk("llu_ready", {31'd0, llu_ready}, {31'd0, rdy});
    have = 1'b0;
    w    = '0;
    if (!rst) begin
      if (wb_act) begin
        w = '{rd: wb_rd, data: wb_data}; have = 1'b1;
      end else if (xfer && llu_rd != 5'd0) begin
        w = '{rd: llu_rd, data: llu_data}; have = 1'b1;
      end
    end
    if (have) exp_q.push_back(w);
    if (rst) begin
      m_cnt = 0; m_force = 1'b0; m_wen = 1'b0; m_wadd = '0; m_wdata = '0;
    end else begin
      if (!m_force) force_n = llu_valid && !rdy && (m_cnt == LIMIT - 1);
      else          force_n = llu_valid && !xfer;
      m_cnt   = (!llu_valid || xfer) ? 0 : ((m_cnt == 15) ? 15 : m_cnt + 1);
      m_force = force_n;
      m_wen   = have;
      if (have) begin m_wadd = w.rd; m_wdata = w.data; end
    end
    @(posedge clk);
    #1;
    chk("stall_pipe", {31'd0, stall_pipe}, {31'd0, m_force});
    chk("RegWrite", {31'd0, RegWrite}, {31'd0, m_wen});
    if (RegWrite) begin
      chk("queue_has_entry", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("w_add", {27'd0, w_add}, {27'd0, w.rd});
        chk("RegWriteData", RegWriteData, w.data);
      end
    end else begin
      chk("w_add_hold", {27'd0, w_add}, {27'd0, m_wadd});
      chk("wdata_hold", RegWriteData, m_wdata);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       output logic xfer);
    rst = r; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    llu_valid = lv; llu_rd = lrd; llu_data = ld;
    step(xfer);
  endtask

  initial begin
    logic        x;
    int          refused;
    logic        pend;
    logic [4:0]  prd;
    logic [31:0] pdat;
    logic        wv;

    rst = 1'b1; wb_valid = 0; wb_rd = 0; wb_data = 0; llu_valid = 0; llu_rd = 0; llu_data = 0;
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, x);
    drive(1, 1, 5'd4, 32'h1111_1111, 1, 5'd6, 32'h2222_2222, x);
    chk("reset_w_add", {27'd0, w_add}, 32'd0);

    // WB only
    drive(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, x);
    drive(0, 0, 0, 0, 0, 0, 0, x);

    // x0 drop from both sources
    drive(0, 1, 5'd0, 32'hAAAA_0000, 0, 0, 0, x);
    drive(0, 0, 0, 0, 1, 5'd0, 32'hBBBB_0000, x);
    chk("x0_llu_xfer", {31'd0, x}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, x);

    // Conflict: WB x3 first, LLU x7 the following cycle
    drive(0, 1, 5'd3, 32'h0000_0033, 1, 5'd7, 32'h1234_5678, x);
    drive(0, 0, 0, 0, 1, 5'd7, 32'h1234_5678, x);
    drive(0, 0, 0, 0, 0, 0, 0, x);

    // Starvation: stall must rise after exactly LIMIT refusals
    refused = 0;
    while (!stall_pipe && refused < 10) begin
      drive(0, 1, 5'(refused + 10), 32'hC000_0000 + refused, 1, 5'd9, 32'hA5A5_5A5A, x);
      refused++;
    end
    chk("refusals_before_stall", refused, LIMIT);
    drive(0, 1, 5'd20, 32'hC0DE_0001, 1, 5'd9, 32'hA5A5_5A5A, x);  // WB still wins in FORCE
    drive(0, 0, 0, 0, 1, 5'd9, 32'hA5A5_5A5A, x);                  // bubble lets LLU through
    drive(0, 0, 0, 0, 0, 0, 0, x);

    // Reset while in FORCE
    refused = 0;
    while (!stall_pipe && refused < 10) begin
      drive(0, 1, 5'd11, 32'h0BAD_0000 + refused, 1, 5'd12, 32'hFEED_F00D, x);
      refused++;
    end
    chk("force_before_reset", {31'd0, stall_pipe}, 32'd1);
    drive(1, 0, 0, 0, 1, 5'd12, 32'hFEED_F00D, x);
    chk("reset_in_force_w_add", {27'd0, w_add}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, x);

    // Counter clear: two refusals, withdraw, then a fresh request
    drive(0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, x);
    drive(0, 1, 5'd1, 32'h3, 1, 5'd2, 32'h2, x);
    drive(0, 0, 0, 0, 0, 0, 0, x);
    refused = 0;
    while (!stall_pipe && refused < 10) begin
      drive(0, 1, 5'd1, 32'h100 + refused, 1, 5'd2, 32'h2, x);
      refused++;
    end
    chk("refusals_after_clear", refused, LIMIT);
    drive(0, 0, 0, 0, 1, 5'd2, 32'h2, x);
    drive(0, 0, 0, 0, 0, 0, 0, x);

    // Random traffic; LLU holds its payload until transferred
    pend = 1'b0; prd = '0; pdat = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pend && ($urandom_range(0, 2) == 0)) begin
        pend = 1'b1; prd = 5'($urandom_range(0, 31)); pdat = $urandom;
      end
      wv = ($urandom_range(0, 3) != 0);
      if (stall_pipe && $urandom_range(0, 1) == 0) wv = 1'b0;
      drive(0, wv, 5'($urandom_range(0, 31)), $urandom, pend, pend ? prd : 5'd0, pend ? pdat : 32'd0, x);
      if (x) pend = 1'b0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, x);
    drive(0, 0, 0, 0, 0, 0, 0, x);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
